// File: rtl/ni_traffic_v3.sv
// ni_traffic_v3: per-node traffic source (interval generator, dest policy, TX FIFO) and checking sink.
// Define NI_SEQ_CHECK_EN to add per-source expected-sequence checking on the sink side.
module ni_traffic_v3 #(
  parameter int NUM_NODES  = 2,
  parameter int ADDR_SZ    = 4,
  parameter int PL_SZ      = 16,
  parameter int HDR_SZ     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int INTERVAL   = 8,
  parameter int DEST_MODE  = 1,
  parameter int DEST       = 0,
  parameter int CNT_W      = 20
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_SZ-1:0]              id,
  input  logic                            send_en,
  output logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] item_out,
  output logic                            req,
  input  logic                            channel_busy,
  input  logic [HDR_SZ+PL_SZ+ADDR_SZ-1:0] item_in,
  input  logic                            valid,
  output logic                            busy,
  output logic [CNT_W-1:0]                tx_count,
  output logic [CNT_W-1:0]                rx_count,
  output logic [CNT_W-1:0]                drop_count,
  output logic [CNT_W-1:0]                err_count
);

  localparam int FLIT_W = HDR_SZ + PL_SZ + ADDR_SZ;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int IW     = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

  logic [FLIT_W-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]      rd_idx, wr_idx;
  logic [AW:0]        fill;
  logic [IW-1:0]      ivl_cnt;
  logic [PL_SZ-1:0]   seq;
  logic [ADDR_SZ-1:0] rr_ptr, rr_next, dest;
  logic [15:0]        lfsr;
  logic [FLIT_W-1:0]  flit;
  logic               attempt, push, pop, full, accept, misroute, err_hit;

  function automatic logic [ADDR_SZ-1:0] next_node(input logic [ADDR_SZ-1:0] n);
    return (32'(n) >= NUM_NODES - 1) ? '0 : n + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign attempt = send_en && (32'(ivl_cnt) == INTERVAL - 1);

  always_comb begin
    rr_next = next_node(rr_ptr);
    if (rr_next == id) rr_next = next_node(rr_next);
  end

  always_comb begin
    dest = id;
    if (NUM_NODES > 1) begin
      case (DEST_MODE)
        0: dest = ADDR_SZ'(DEST);
        1: dest = rr_ptr;
        default: begin
          dest = ADDR_SZ'(32'(lfsr) % NUM_NODES);
          if (dest == id) dest = next_node(id);
        end
      endcase
    end
  end

  assign flit = {HDR_SZ'(id), seq, dest};

  // Sequence number advances on every attempt, so drops leave visible gaps downstream.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ivl_cnt <= '0;
      seq     <= '0;
      rr_ptr  <= next_node(id);
      lfsr    <= 16'hACE1 ^ 16'(id);
    end else begin
      if (send_en) ivl_cnt <= attempt ? '0 : ivl_cnt + 1'b1;
      if (attempt) begin
        seq    <= seq + 1'b1;
        rr_ptr <= rr_next;
        lfsr   <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
    end
  end

  assign req      = (fill != '0);
  assign full     = (32'(fill) == FIFO_DEPTH);
  assign pop      = req && !channel_busy;
  assign push     = attempt && (!full || pop);
  assign item_out = mem[rd_idx];

  // When full, a simultaneous pop frees the head slot, which is the write slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_idx <= '0;
      wr_idx <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        mem[wr_idx] <= flit;
        wr_idx      <= wr_idx + 1'b1;
      end
      if (pop) rd_idx <= rd_idx + 1'b1;
      if (push && !pop)      fill <= fill + 1'b1;
      else if (pop && !push) fill <= fill - 1'b1;
    end
  end

  assign accept   = valid && !busy;
  assign misroute = (item_in[ADDR_SZ-1:0] != id);

`ifdef NI_SEQ_CHECK_EN
  logic [PL_SZ-1:0]  exp_seq [NUM_NODES];
  logic [HDR_SZ-1:0] hdr_in;
  logic [PL_SZ-1:0]  pl_in;
  logic              seq_err;

  assign hdr_in = item_in[FLIT_W-1 -: HDR_SZ];
  assign pl_in  = item_in[ADDR_SZ +: PL_SZ];

  // Unknown sources stay flagged; match and resync both leave expected = payload + 1.
  always_comb begin
    seq_err = 1'b1;
    for (int n = 0; n < NUM_NODES; n++)
      if (32'(hdr_in) == n) seq_err = (pl_in != exp_seq[n]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int n = 0; n < NUM_NODES; n++) exp_seq[n] <= '0;
    end else if (accept && !misroute) begin
      for (int n = 0; n < NUM_NODES; n++)
        if (32'(hdr_in) == n) exp_seq[n] <= pl_in + 1'b1;
    end
  end

  assign err_hit = accept && (misroute || seq_err);
`else
  logic unused_flit_bits;
  assign unused_flit_bits = ^item_in[FLIT_W-1:ADDR_SZ];
  assign err_hit = accept && misroute;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b1;
      tx_count   <= '0;
      rx_count   <= '0;
      drop_count <= '0;
      err_count  <= '0;
    end else begin
      busy <= 1'b0;
      if (pop)              tx_count   <= sat_inc(tx_count);
      if (attempt && !push) drop_count <= sat_inc(drop_count);
      if (accept)           rx_count   <= sat_inc(rx_count);
      if (err_hit)          err_count  <= sat_inc(err_count);
    end
  end

endmodule

// File: tb/tb_ni_traffic_v3.sv
// tb_ni_traffic_v3: directed and randomized checks of ni_traffic_v3 against a queue-based model.
// Two instances: a fixed-destination node and a 4-node round-robin node with narrow counters.
module tb_ni_traffic_v3;

  localparam int FW    = 24;
  localparam int NB    = 4;
  localparam int ID_B  = 2;
  localparam int DEP_B = 4;
  localparam int INT_B = 1;
  localparam int SAT_B = 15;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    id_a = 4'd0;
  logic          send_en_a = 1'b0, cb_a = 1'b0, valid_a = 1'b0;
  logic [FW-1:0] item_in_a = '0, item_out_a;
  logic          req_a, busy_a;
  logic [19:0]   tx_a, rx_a, drop_a, err_a;

  logic [3:0]    id_b = 4'(ID_B);
  logic          send_en_b = 1'b0, cb_b = 1'b0, valid_b = 1'b0;
  logic [FW-1:0] item_in_b = '0, item_out_b;
  logic          req_b, busy_b;
  logic [3:0]    tx_b, rx_b, drop_b, err_b;

  int checks = 0;
  int errors = 0;

  ni_traffic_v3 #(.NUM_NODES(2), .FIFO_DEPTH(4), .INTERVAL(4), .DEST_MODE(0), .DEST(1), .CNT_W(20)) dut_a (
    .clk(clk), .reset(reset), .id(id_a), .send_en(send_en_a), .item_out(item_out_a), .req(req_a),
    .channel_busy(cb_a), .item_in(item_in_a), .valid(valid_a), .busy(busy_a), .tx_count(tx_a),
    .rx_count(rx_a), .drop_count(drop_a), .err_count(err_a));

  ni_traffic_v3 #(.NUM_NODES(NB), .FIFO_DEPTH(DEP_B), .INTERVAL(INT_B), .DEST_MODE(1), .DEST(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id(id_b), .send_en(send_en_b), .item_out(item_out_b), .req(req_b),
    .channel_busy(cb_b), .item_in(item_in_b), .valid(valid_b), .busy(busy_b), .tx_count(tx_b),
    .rx_count(rx_b), .drop_count(drop_b), .err_count(err_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    send_en_a = 0; cb_a = 0; valid_a = 0; item_in_a = '0;
    send_en_b = 0; cb_b = 0; valid_b = 0; item_in_b = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    repeat (2) tick();
    reset = 1;
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    repeat (3) begin
      tick();
      checks++;
      if ({busy_a, busy_b, req_a, req_b, item_out_a} !== {4'b1100, 24'd0}) begin
        errors++;
        $display("[TB] FAIL reset_flags got %b%b%b%b item %h exp 1100 item 0", busy_a, busy_b, req_a, req_b, item_out_a);
      end
      checks++;
      if ({tx_a, rx_a, drop_a, err_a, tx_b, rx_b, drop_b, err_b} !== '0) begin
        errors++;
        $display("[TB] FAIL reset_counters got %h %h %h %h %h %h %h %h exp all 0",
                 tx_a, rx_a, drop_a, err_a, tx_b, rx_b, drop_b, err_b);
      end
    end
    reset = 1;
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_before_edge got %b exp 1", busy_a);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({busy_a, busy_b, req_a, req_b, tx_a, drop_a, tx_b, drop_b} !== '0) begin
        errors++;
        $display("[TB] FAIL idle cycle %0d got busy %b%b req %b%b tx %0d %0d drop %0d %0d exp all 0",
                 i, busy_a, busy_b, req_a, req_b, tx_a, tx_b, drop_a, drop_b);
      end
    end
  endtask

  task automatic test_fixed_mode();
    logic [FW-1:0] exp_item;
    do_reset();
    send_en_a = 1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      checks++;
      if (req_a !== (i % 4 == 0)) begin
        errors++;
        $display("[TB] FAIL fixed_req cycle %0d got %b exp %b", i, req_a, (i % 4 == 0));
      end
      if (i % 4 == 0) begin
        exp_item = {4'd0, 16'(i / 4 - 1), 4'd1};
        checks++;
        if (item_out_a !== exp_item) begin
          errors++;
          $display("[TB] FAIL fixed_item cycle %0d got %h exp %h", i, item_out_a, exp_item);
        end
      end
    end
    send_en_a = 0;
    tick();
    checks++;
    if ({req_a, tx_a, drop_a} !== {1'b0, 20'd10, 20'd0}) begin
      errors++;
      $display("[TB] FAIL fixed_counts got req %b tx %0d drop %0d exp req 0 tx 10 drop 0", req_a, tx_a, drop_a);
    end
  endtask

  task automatic test_async_reset();
    cb_a = 1;
    send_en_a = 1;
    repeat (12) tick();
    send_en_a = 0;
    checks++;
    if ({req_a, item_out_a} !== {1'b1, 4'd0, 16'd10, 4'd1}) begin
      errors++;
      $display("[TB] FAIL pre_reset_head got req %b item %h exp req 1 item 000a1", req_a, item_out_a);
    end
    #2;
    reset = 0;
    #1;
    checks++;
    if ({req_a, busy_a, item_out_a, tx_a, drop_a} !== {2'b01, 24'd0, 40'd0}) begin
      errors++;
      $display("[TB] FAIL async_reset got req %b busy %b item %h tx %0d drop %0d exp 0 1 0 0 0",
               req_a, busy_a, item_out_a, tx_a, drop_a);
    end
    tick();
    reset = 1;
    cb_a = 0;
    tick();
    checks++;
    if ({req_a, tx_a} !== 21'd0) begin
      errors++;
      $display("[TB] FAIL post_reset_empty got req %b tx %0d exp 0 0", req_a, tx_a);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] dests [4] = '{4'd3, 4'd0, 4'd1, 4'd3};
    logic [FW-1:0] exp_item;
    do_reset();
    cb_b = 1;
    send_en_b = 1;
    repeat (10) tick();
    send_en_b = 0;
    checks++;
    if ({req_b, drop_b, tx_b} !== {1'b1, 4'd6, 4'd0}) begin
      errors++;
      $display("[TB] FAIL bp_full got req %b drop %0d tx %0d exp 1 6 0", req_b, drop_b, tx_b);
    end
    cb_b = 0;
    for (int k = 0; k < 4; k++) begin
      exp_item = {4'(ID_B), 16'(k), dests[k]};
      checks++;
      if ({req_b, item_out_b} !== {1'b1, exp_item}) begin
        errors++;
        $display("[TB] FAIL bp_drain %0d got req %b item %h exp req 1 item %h", k, req_b, item_out_b, exp_item);
      end
      tick();
    end
    checks++;
    if ({req_b, tx_b, drop_b} !== {1'b0, 4'd4, 4'd6}) begin
      errors++;
      $display("[TB] FAIL bp_done got req %b tx %0d drop %0d exp 0 4 6", req_b, tx_b, drop_b);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] dests [6] = '{4'd3, 4'd0, 4'd1, 4'd3, 4'd0, 4'd1};
    logic [FW-1:0] exp_item;
    do_reset();
    send_en_b = 1;
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_item = {4'(ID_B), 16'(i), dests[i]};
      checks++;
      if ({req_b, item_out_b} !== {1'b1, exp_item}) begin
        errors++;
        $display("[TB] FAIL rr_dest %0d got req %b item %h exp req 1 item %h", i, req_b, item_out_b, exp_item);
      end
    end
    send_en_b = 0;
    tick();
  endtask

  task automatic test_sink();
    logic [3:0] dst [4] = '{4'(ID_B), 4'(ID_B), 4'(ID_B), 4'd3};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      item_in_b = {4'd0, 16'(i), dst[i]};
      valid_b = 1;
      tick();
    end
    valid_b = 0;
    tick();
    checks++;
    if ({rx_b, err_b} !== {4'd4, 4'd1}) begin
      errors++;
      $display("[TB] FAIL sink_counts got rx %0d err %0d exp rx 4 err 1", rx_b, err_b);
    end
  endtask

`ifdef NI_SEQ_CHECK_EN
  task automatic test_seq_check();
    logic [15:0] pls [3] = '{16'd0, 16'd1, 16'd3};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      item_in_b = {4'd0, pls[i], 4'(ID_B)};
      valid_b = 1;
      tick();
    end
    valid_b = 0;
    tick();
    checks++;
    if ({rx_b, err_b} !== {4'd3, 4'd1}) begin
      errors++;
      $display("[TB] FAIL seq_check got rx %0d err %0d exp rx 3 err 1", rx_b, err_b);
    end
  endtask
`endif

  task automatic test_random_traffic();
    logic [FW-1:0] q [$];
    int rr_list [$];
    int ivl = 0, seq = 0, n_att = 0, m_tx = 0, m_drop = 0;
    logic pop, attempt;
    for (int k = 1; k < NB; k++) rr_list.push_back((ID_B + k) % NB);
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      send_en_b = ($urandom_range(0, 3) != 0);
      cb_b = 1'($urandom_range(0, 1));
      checks++;
      if ({req_b, tx_b, drop_b} !== {(q.size() != 0), 4'(m_tx), 4'(m_drop)}) begin
        errors++;
        $display("[TB] FAIL rand_state cyc %0d got req %b tx %0d drop %0d exp req %b tx %0d drop %0d",
                 cyc, req_b, tx_b, drop_b, (q.size() != 0), m_tx, m_drop);
      end
      if (q.size() != 0) begin
        checks++;
        if (item_out_b !== q[0]) begin
          errors++;
          $display("[TB] FAIL rand_head cyc %0d got %h exp %h", cyc, item_out_b, q[0]);
        end
      end
      pop = (q.size() != 0) && !cb_b;
      attempt = 0;
      if (send_en_b) begin
        if (ivl == INT_B - 1) begin
          ivl = 0;
          attempt = 1;
        end else ivl++;
      end
      if (pop) begin
        void'(q.pop_front());
        m_tx = (m_tx < SAT_B) ? m_tx + 1 : SAT_B;
      end
      if (attempt) begin
        if (q.size() < DEP_B)
          q.push_back({4'(ID_B), 16'(seq), 4'(rr_list[n_att % (NB - 1)])});
        else
          m_drop = (m_drop < SAT_B) ? m_drop + 1 : SAT_B;
        seq = (seq + 1) % 65536;
        n_att++;
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_random_sink();
    int exp_seq [NB] = '{0, 0, 0, 0};
    int m_rx = 0, m_err = 0, dst, hdr;
    do_reset();
    for (int cyc = 0; cyc < 60; cyc++) begin
      valid_b = 1'($urandom_range(0, 1));
      dst = $urandom_range(0, NB - 1);
      hdr = $urandom_range(0, NB - 1);
      item_in_b = {4'(hdr), 16'(exp_seq[hdr]), 4'(dst)};
      if (valid_b) begin
        m_rx = (m_rx < SAT_B) ? m_rx + 1 : SAT_B;
        if (dst != ID_B) m_err = (m_err < SAT_B) ? m_err + 1 : SAT_B;
        else exp_seq[hdr] = (exp_seq[hdr] + 1) % 65536;
      end
      tick();
      checks++;
      if ({busy_b, rx_b, err_b} !== {1'b0, 4'(m_rx), 4'(m_err)}) begin
        errors++;
        $display("[TB] FAIL rand_sink cyc %0d got busy %b rx %0d err %0d exp busy 0 rx %0d err %0d",
                 cyc, busy_b, rx_b, err_b, m_rx, m_err);
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_fixed_mode();
    test_async_reset();
    test_backpressure();
    test_round_robin();
    test_sink();
`ifdef NI_SEQ_CHECK_EN
    test_seq_check();
`endif
    test_random_traffic();
    test_random_sink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
